uparc_execute_mc: RTL and testbench
===================================

# uparc_execute_mc

Parametrised multi-cycle execute stage for the Ultiparc core. It sits between decode and memory and replaces the fixed 32-bit single-cycle stage. It adds:
- a configurable datapath width;
- an integrated iterative unsigned multiply/divide sequencer with a ready/valid handshake;
- explicit pipeline-bubble outputs;
- abort of an in-flight multi-cycle operation on nullify.

Results of every operation appear on one registered output set consumed by the memory stage.

## Interface
- DATA_WIDTH, 32, datapath/register width; even, >= 8.
- REGNO_WIDTH, 5, register number width.
- MD_STEP, 1, quotient/product bits resolved per cycle; 1, 2 or 4; must divide DATA_WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  decode presents an instruction.
- o_ready  out  1  stage accepts; = !busy && !i_stall.
- i_stall  in  1  downstream stall; freezes output register.
- i_nullify  in  1  flush: incoming instruction becomes bubble; aborts in-flight mul/div.
- i_op  in  4  opcode: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLTU, 7 MUL(low), 8 MULHU, 9 DIVU, 10 REMU, 11 BEQ, 12 BNE, 13 JR.
- i_ovf_en  in  1  trap on signed overflow for ADD/SUB.
- i_link  in  1  write i_pc_link to rd when jump taken.
- i_rd_no  in  REGNO_WIDTH  destination register.
- i_rs, i_rt  in  DATA_WIDTH  operands.
- i_imm  in  DATA_WIDTH  pre-shifted branch offset.
- i_pc, i_pc_link  in  DATA_WIDTH  PC of the instruction; link address.
- o_valid  out  1  output register holds a real instruction.
- o_rd_no  out  REGNO_WIDTH  destination; 0 for bubbles, not-taken branches and trapped instructions.
- o_result  out  DATA_WIDTH  result.
- o_jump_valid  out  1  taken branch/jump, target aligned.
- o_jump_addr  out  DATA_WIDTH  target.
- o_ovf_error, o_addr_error  out  1  overflow trap; misaligned taken target.
- o_busy  out  1  mul/div sequencer active.

## Operation
- Accept occurs on an edge with i_valid && o_ready && !i_nullify.
- i_valid && o_ready && i_nullify loads a bubble: o_valid=0, all flags 0.
- Single-cycle ops (0-6, 11-13) write the output register on the accept edge.
- All arithmetic is modulo 2^DATA_WIDTH.
- ADD/SUB overflow is signed two's complement.
  - With i_ovf_en set: o_ovf_error=1 and o_rd_no=0.
- SLTU result is 1 or 0, zero-extended.
- BEQ/BNE:
  - Target = i_pc + i_imm.
  - Taken with i_link set: o_result=i_pc_link and rd is kept.
  - Not taken: o_rd_no=0.
- JR: always taken, target = i_rs.
- A taken jump with target[1:0]!=0 sets o_addr_error=1 and keeps o_jump_valid=0.
- Mul/div FSM states:
  - IDLE: accepting a mul/div op latches the operands, loads counter = DATA_WIDTH/MD_STEP, sets o_busy, and goes to BUSY. The output register is loaded with a bubble.
  - BUSY: one MD_STEP-bit iteration per cycle (shift-add multiply, restoring divide). Iterations continue regardless of i_stall. Counter decrements; at 1 → DONE.
  - DONE: when !i_stall, writes the result to the output register (o_valid=1) and goes to IDLE. While i_stall, it holds in DONE.
  - i_nullify in BUSY or DONE: go to IDLE next edge, no result is written, output is a bubble.
- Division by zero: DIVU result = all ones; REMU result = i_rs.
- Only one operand set is latched; MUL/MULHU both compute the full 2·DATA_WIDTH product.

## Timing
- Reset (rst high at an edge):
  - All outputs 0: o_valid, o_rd_no, o_result, o_jump_valid, o_jump_addr, o_ovf_error, o_addr_error, o_busy.
  - FSM in IDLE, counter 0.
  - Reset mid-BUSY discards the operation.
- Single-cycle latency: accepted at edge N, visible after edge N.
- Mul/div latency: accepted at edge N; o_busy=1 after edge N; result visible after edge N + DATA_WIDTH/MD_STEP + 1 if unstalled.
- o_ready is 0 from the accept edge until the edge leaving DONE. The next instruction can be accepted on the same edge as the DONE write-out? No: o_ready stays low during DONE.
- i_stall high: output register and FSM state DONE hold; BUSY keeps iterating.
- o_ready is combinational from i_stall and busy; no other combinational input→output paths.

## Test plan
- Reset, then ADD 0x7FFFFFFF+1 with i_ovf_en=1 → next cycle o_ovf_error=1, o_rd_no=0; same with i_ovf_en=0 → o_result=0x80000000, o_rd_no preserved.
- MULHU 0xFFFFFFFF×0xFFFFFFFF, MD_STEP=1 → o_busy for 33 cycles, then o_valid=1, o_result=0xFFFFFFFE; MUL → 0x00000001.
- DIVU 100/7 → 14; REMU → 2; DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; repeat with MD_STEP=4 → latency 9.
- BEQ equal, i_pc=0x100, i_imm=0x20 → o_jump_valid=1, o_jump_addr=0x120; JR i_rs=0x102 → o_addr_error=1, o_jump_valid=0; BNE equal → o_rd_no=0.
- Nullify at BUSY cycle 10 → no result ever emitted, o_ready=1 next cycle; rst asserted mid-BUSY → all outputs 0 next cycle.
- Hold i_stall through DONE for 5 cycles → result appears on the first unstalled edge, exactly once.

Source files
------------

// File: rtl/uparc_execute_mc.sv
// Ultiparc multi-cycle execute stage: single-cycle ALU/branch ops plus an iterative
// unsigned multiply/divide sequencer, all feeding one registered output set.
module uparc_execute_mc #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned REGNO_WIDTH = 5,
    parameter int unsigned MD_STEP     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_stall,
    input  logic                   i_nullify,
    input  logic [3:0]             i_op,
    input  logic                   i_ovf_en,
    input  logic                   i_link,
    input  logic [REGNO_WIDTH-1:0] i_rd_no,
    input  logic [DATA_WIDTH-1:0]  i_rs,
    input  logic [DATA_WIDTH-1:0]  i_rt,
    input  logic [DATA_WIDTH-1:0]  i_imm,
    input  logic [DATA_WIDTH-1:0]  i_pc,
    input  logic [DATA_WIDTH-1:0]  i_pc_link,
    output logic                   o_valid,
    output logic [REGNO_WIDTH-1:0] o_rd_no,
    output logic [DATA_WIDTH-1:0]  o_result,
    output logic                   o_jump_valid,
    output logic [DATA_WIDTH-1:0]  o_jump_addr,
    output logic                   o_ovf_error,
    output logic                   o_addr_error,
    output logic                   o_busy
);
    localparam int unsigned NumIter = DATA_WIDTH / MD_STEP;
    localparam int unsigned CntW    = $clog2(NumIter + 1);
    localparam int unsigned Msb     = DATA_WIDTH - 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [1:0]             md_op_q, md_op_d;  // 0 MUL, 1 MULHU, 2 DIVU, 3 REMU
    logic [REGNO_WIDTH-1:0] md_rd_q, md_rd_d;
    logic [DATA_WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic                   valid_q, valid_d, jv_q, jv_d, ovf_q, ovf_d, aerr_q, aerr_d;
    logic [REGNO_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0]  res_q, res_d, ja_q, ja_d;

    logic                   is_md, accept, taken, is_br, add_ovf, sub_ovf;
    logic [DATA_WIDTH-1:0]  sum, diff, target, it_hi, it_lo;
    logic [DATA_WIDTH:0]    it_acc;
    logic                   sc_jv, sc_ovf, sc_aerr;
    logic [REGNO_WIDTH-1:0] sc_rd;
    logic [DATA_WIDTH-1:0]  sc_res, sc_ja;

    assign is_md   = (i_op >= 4'd7) && (i_op <= 4'd10);
    assign o_busy  = (state_q != StIdle);
    assign o_ready = !o_busy && !i_stall;
    assign accept  = i_valid && o_ready && !i_nullify;

    assign sum     = i_rs + i_rt;
    assign diff    = i_rs - i_rt;
    assign add_ovf = (i_rs[Msb] == i_rt[Msb]) && (sum[Msb] != i_rs[Msb]);
    assign sub_ovf = (i_rs[Msb] != i_rt[Msb]) && (diff[Msb] != i_rs[Msb]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            md_op_q <= '0;
            md_rd_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            valid_q <= 1'b0;
            rd_q    <= '0;
            res_q   <= '0;
            jv_q    <= 1'b0;
            ja_q    <= '0;
            ovf_q   <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            md_op_q <= md_op_d;
            md_rd_q <= md_rd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            valid_q <= valid_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            jv_q    <= jv_d;
            ja_q    <= ja_d;
            ovf_q   <= ovf_d;
            aerr_q  <= aerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept && is_md) state_d = StBusy;
            StBusy: begin
                if (i_nullify) state_d = StIdle;
                else if (cnt_q == CntW'(1)) state_d = StDone;
            end
            StDone: if (i_nullify || !i_stall) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // MD_STEP single-bit iterations: shift-add multiply or restoring divide.
    always_comb begin
        it_hi  = hi_q;
        it_lo  = lo_q;
        it_acc = '0;
        for (int i = 0; i < MD_STEP; i++) begin
            if (md_op_q[1]) begin
                it_acc = {it_hi, it_lo[Msb]};
                it_lo  = {it_lo[Msb-1:0], 1'b0};
                if (it_acc >= {1'b0, opnd_q}) begin
                    it_acc   = it_acc - {1'b0, opnd_q};
                    it_lo[0] = 1'b1;
                end
                it_hi = it_acc[Msb:0];
            end else begin
                it_acc = {1'b0, it_hi} + {1'b0, it_lo[0] ? opnd_q : {DATA_WIDTH{1'b0}}};
                it_lo  = {it_acc[0], it_lo[Msb:1]};
                it_hi  = it_acc[DATA_WIDTH:1];
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        md_op_d = md_op_q;
        md_rd_d = md_rd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        if (state_q == StIdle && accept && is_md) begin
            cnt_d   = CntW'(NumIter);
            md_op_d = 2'(i_op - 4'd7);
            md_rd_d = i_rd_no;
            hi_d    = '0;
            lo_d    = (i_op >= 4'd9) ? i_rs : i_rt;
            opnd_d  = (i_op >= 4'd9) ? i_rt : i_rs;
        end else if (state_q == StBusy) begin
            cnt_d = cnt_q - CntW'(1);
            hi_d  = it_hi;
            lo_d  = it_lo;
        end
    end

    always_comb begin
        sc_res = '0;
        sc_rd  = i_rd_no;
        sc_ovf = 1'b0;
        taken  = 1'b0;
        is_br  = 1'b0;
        target = '0;
        case (i_op)
            4'd1: begin
                sc_res = sum;
                sc_ovf = i_ovf_en && add_ovf;
            end
            4'd2: begin
                sc_res = diff;
                sc_ovf = i_ovf_en && sub_ovf;
            end
            4'd3: sc_res = i_rs & i_rt;
            4'd4: sc_res = i_rs | i_rt;
            4'd5: sc_res = i_rs ^ i_rt;
            4'd6: sc_res = {{(DATA_WIDTH-1){1'b0}}, i_rs < i_rt};
            4'd11, 4'd12: begin
                is_br  = 1'b1;
                taken  = (i_rs == i_rt) ^ (i_op == 4'd12);
                target = i_pc + i_imm;
            end
            4'd13: begin
                is_br  = 1'b1;
                taken  = 1'b1;
                target = i_rs;
            end
            default: sc_rd = '0;
        endcase
        sc_jv   = 1'b0;
        sc_ja   = '0;
        sc_aerr = 1'b0;
        if (sc_ovf) sc_rd = '0;
        if (is_br) begin
            if (!taken) begin
                sc_rd = '0;
            end else if (target[1:0] != 2'b00) begin
                sc_aerr = 1'b1;
                sc_rd   = '0;
            end else begin
                sc_jv = 1'b1;
                sc_ja = target;
                if (i_link) sc_res = i_pc_link;
                else        sc_rd  = '0;
            end
        end
    end

    // Output register: frozen under stall, otherwise result or bubble.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        res_d   = res_q;
        jv_d    = jv_q;
        ja_d    = ja_q;
        ovf_d   = ovf_q;
        aerr_d  = aerr_q;
        if (!i_stall) begin
            valid_d = 1'b0;
            rd_d    = '0;
            res_d   = '0;
            jv_d    = 1'b0;
            ja_d    = '0;
            ovf_d   = 1'b0;
            aerr_d  = 1'b0;
            if (state_q == StDone && !i_nullify) begin
                valid_d = 1'b1;
                rd_d    = md_rd_q;
                res_d   = md_op_q[0] ? hi_q : lo_q;
            end else if (state_q == StIdle && accept && !is_md) begin
                valid_d = 1'b1;
                rd_d    = sc_rd;
                res_d   = sc_res;
                jv_d    = sc_jv;
                ja_d    = sc_ja;
                ovf_d   = sc_ovf;
                aerr_d  = sc_aerr;
            end
        end
    end

    assign o_valid      = valid_q;
    assign o_rd_no      = rd_q;
    assign o_result     = res_q;
    assign o_jump_valid = jv_q;
    assign o_jump_addr  = ja_q;
    assign o_ovf_error  = ovf_q;
    assign o_addr_error = aerr_q;

endmodule

// File: tb/tb_uparc_execute_mc.sv
// Directed bench for uparc_execute_mc: two instances (MD_STEP 1 and 4) share one stimulus.
module tb_uparc_execute_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0, i_stall = 1'b0, i_nullify = 1'b0;
    logic [3:0]  i_op = '0;
    logic        i_ovf_en = 1'b0, i_link = 1'b0;
    logic [4:0]  i_rd_no = '0;
    logic [31:0] i_rs = '0, i_rt = '0, i_imm = '0, i_pc = '0, i_pc_link = '0;

    logic        rdy1, val1, jv1, ovf1, aerr1, busy1;
    logic [4:0]  rd1;
    logic [31:0] res1, ja1;
    logic        rdy4, val4, jv4, ovf4, aerr4, busy4;
    logic [4:0]  rd4;
    logic [31:0] res4, ja4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uparc_execute_mc #(.DATA_WIDTH(32), .REGNO_WIDTH(5), .MD_STEP(1)) dut1 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(rdy1), .i_stall(i_stall),
        .i_nullify(i_nullify), .i_op(i_op), .i_ovf_en(i_ovf_en), .i_link(i_link),
        .i_rd_no(i_rd_no), .i_rs(i_rs), .i_rt(i_rt), .i_imm(i_imm), .i_pc(i_pc),
        .i_pc_link(i_pc_link), .o_valid(val1), .o_rd_no(rd1), .o_result(res1),
        .o_jump_valid(jv1), .o_jump_addr(ja1), .o_ovf_error(ovf1), .o_addr_error(aerr1),
        .o_busy(busy1)
    );

    uparc_execute_mc #(.DATA_WIDTH(32), .REGNO_WIDTH(5), .MD_STEP(4)) dut4 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(rdy4), .i_stall(i_stall),
        .i_nullify(i_nullify), .i_op(i_op), .i_ovf_en(i_ovf_en), .i_link(i_link),
        .i_rd_no(i_rd_no), .i_rs(i_rs), .i_rt(i_rt), .i_imm(i_imm), .i_pc(i_pc),
        .i_pc_link(i_pc_link), .o_valid(val4), .o_rd_no(rd4), .o_result(res4),
        .o_jump_valid(jv4), .o_jump_addr(ja4), .o_ovf_error(ovf4), .o_addr_error(aerr4),
        .o_busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " val1"}, {31'd0, val1}, 32'd0);
        check({tag, " rd1"}, {27'd0, rd1}, 32'd0);
        check({tag, " res1"}, res1, 32'd0);
        check({tag, " flags1"}, {28'd0, jv1, ovf1, aerr1, busy1}, 32'd0);
        check({tag, " ja1"}, ja1, 32'd0);
        check({tag, " val4"}, {31'd0, val4}, 32'd0);
        check({tag, " res4"}, res4, 32'd0);
        check({tag, " flags4"}, {28'd0, jv4, ovf4, aerr4, busy4}, 32'd0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        i_valid = 1'b1;
        i_op    = op;
        i_rs    = a;
        i_rt    = b;
        i_rd_no = rd;
        step();
        i_valid = 1'b0;
    endtask

    // Result must appear after 9 edges on the MD_STEP=4 unit and 33 on the MD_STEP=1 unit.
    task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        issue(op, a, b, 5'd7);
        check({tag, " busy1"}, {31'd0, busy1}, 32'd1);
        check({tag, " busy4"}, {31'd0, busy4}, 32'd1);
        check({tag, " bubble"}, {30'd0, val1, rdy1}, 32'd0);
        for (int k = 1; k <= 33; k++) begin
            step();
            if (k == 8) check({tag, " s4 early"}, {31'd0, val4}, 32'd0);
            if (k == 9) begin
                check({tag, " s4 valid"}, {31'd0, val4}, 32'd1);
                check({tag, " s4 res"}, res4, exp);
                check({tag, " s4 rd"}, {27'd0, rd4}, 32'd7);
            end
            if (k == 32) check({tag, " s1 early"}, {30'd0, val1, busy1}, 32'd1);
            if (k == 33) begin
                check({tag, " s1 valid"}, {30'd0, val1, busy1}, 32'd2);
                check({tag, " s1 res"}, res1, exp);
                check({tag, " s1 rd"}, {27'd0, rd1}, 32'd7);
            end
        end
        step();
    endtask

    initial begin
        int seen;
        step();
        step();
        check_zero("reset");
        rst = 1'b0;
        step();
        check("ready after reset", {30'd0, rdy1, rdy4}, 32'd3);

        i_ovf_en = 1'b1;
        issue(4'd1, 32'h7FFF_FFFF, 32'h1, 5'd5);
        check("add ovf flag", {30'd0, val1, ovf1}, 32'd3);
        check("add ovf rd", {27'd0, rd1}, 32'd0);
        i_ovf_en = 1'b0;
        issue(4'd1, 32'h7FFF_FFFF, 32'h1, 5'd5);
        check("add wrap res", res1, 32'h8000_0000);
        check("add wrap rd/ovf", {26'd0, rd1, ovf1}, {26'd0, 5'd5, 1'b0});
        i_ovf_en = 1'b1;
        issue(4'd2, 32'd5, 32'd7, 5'd3);
        check("sub res", res1, 32'hFFFF_FFFE);
        check("sub no ovf", {26'd0, rd1, ovf1}, {26'd0, 5'd3, 1'b0});
        issue(4'd2, 32'h8000_0000, 32'd1, 5'd3);
        check("sub ovf", {26'd0, rd1, ovf1}, 32'd1);
        i_ovf_en = 1'b0;
        issue(4'd6, 32'd3, 32'd5, 5'd2);
        check("sltu lt", res1, 32'd1);
        issue(4'd6, 32'hFFFF_FFFF, 32'd5, 5'd2);
        check("sltu ge", res1, 32'd0);
        issue(4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd4);
        check("xor", res1, 32'hFF00_EDCB);

        i_pc = 32'h100;
        i_imm = 32'h20;
        i_pc_link = 32'h108;
        i_link = 1'b1;
        issue(4'd11, 32'd9, 32'd9, 5'd31);
        check("beq jump", {30'd0, jv1, aerr1}, 32'd2);
        check("beq addr", ja1, 32'h120);
        check("beq link", res1, 32'h108);
        check("beq rd", {27'd0, rd1}, 32'd31);
        i_link = 1'b0;
        issue(4'd13, 32'h102, 32'd0, 5'd31);
        check("jr misaligned", {29'd0, val1, jv1, aerr1}, 32'd5);
        check("jr misaligned rd", {27'd0, rd1}, 32'd0);
        issue(4'd12, 32'd9, 32'd9, 5'd31);
        check("bne not taken", {29'd0, val1, jv1, aerr1}, 32'd4);
        check("bne rd", {27'd0, rd1}, 32'd0);

        run_md("mulhu", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_md("mul", 4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_md("divu", 4'd9, 32'd100, 32'd7, 32'd14);
        run_md("remu", 4'd10, 32'd100, 32'd7, 32'd2);
        run_md("divu0", 4'd9, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_md("remu0", 4'd10, 32'd5, 32'd0, 32'd5);

        // Nullify while both sequencers are still iterating.
        issue(4'd9, 32'd100, 32'd7, 5'd7);
        for (int k = 0; k < 4; k++) step();
        i_nullify = 1'b1;
        step();
        i_nullify = 1'b0;
        check("nullify idle", {28'd0, busy1, busy4, rdy1, rdy4}, 32'd3);
        check("nullify bubble", {30'd0, val1, val4}, 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (val1 || val4) seen++;
        end
        check("nullify no result", seen, 32'd0);

        issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        step();
        check_zero("reset mid-busy");
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (val1 || val4) seen++;
        end
        check("reset no result", seen, 32'd0);

        // Stall holds DONE for five cycles on the MD_STEP=1 unit.
        issue(4'd9, 32'd100, 32'd7, 5'd9);
        for (int k = 1; k <= 31; k++) step();
        i_stall = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (val1) seen++;
        end
        check("stall no early result", seen, 32'd0);
        check("stall busy/ready", {30'd0, busy1, rdy1}, 32'd2);
        check("stall ready4", {31'd0, rdy4}, 32'd0);
        i_stall = 1'b0;
        step();
        check("stall release", {30'd0, val1, busy1}, 32'd2);
        check("stall res", res1, 32'd14);
        check("stall rd", {27'd0, rd1}, 32'd9);
        step();
        check("stall once", {30'd0, val1, rdy1}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
